spike_packetizer: RTL
=====================

# spike_packetizer

Converts spike events from one node's neuron bank into 32-bit NoC spike packets and queues them for the router's local input port. It sits directly upstream of the router local port, on the network clock. A programmable per-neuron routing table supplies each packet's destination. A small output FIFO absorbs bursts while the mesh is back-pressured.

## Interface
- NUM_NEURONS, 4, neurons in the attached bank (1..16)
- ROUTER_ADDR_WIDTH, 8, router address width, {x[3:0], y[3:0]}
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  network clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- router_addr  in  ROUTER_ADDR_WIDTH  this node's address; used as packet source field
- spike_in  in  NUM_NEURONS  spike mask for one timestep; sampled only when spike_valid=1
- spike_valid  in  1  single-cycle strobe qualifying spike_in
- cfg_we  in  1  routing-table write strobe
- cfg_idx  in  4  neuron index to write; writes with cfg_idx ≥ NUM_NEURONS are ignored
- cfg_wdata  in  21  {enable[20], dest_router[19:12], dest_neuron[11:0]}
- out_packet  out  32  head-of-FIFO packet
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  router local_in_ready
- busy  out  1  pending mask non-zero or FIFO non-empty
- drop_count  out  16  saturating count of spikes lost to overflow
- overflow  out  1  sticky; set on the first drop; cleared only by rst

## Operation
- Packet format: [31:24] dest_router, [23:12] dest_neuron, [11:4] router_addr, [3:0] source neuron index.
- Routing table: NUM_NEURONS entries of 21 bits. Reset clears every entry, so all neurons start disabled. A write takes effect on the next cycle.
- Pending mask P, NUM_NEURONS bits:
  - When spike_valid=1, P ← (P & ~served) | spike_in.
  - A bit already set in P, not served this cycle, and set again in spike_in counts as one drop per such bit.
- FSM has two states:
  - IDLE: P == 0. Moves to SCAN on the cycle after P becomes non-zero.
  - SCAN: each cycle selects the lowest set bit i of P.
    - Entry i enabled and FIFO not full: push the packet and clear bit i ("served").
    - Entry i disabled: clear bit i with no push. This is a silent filter and not a drop.
    - Entry i enabled and FIFO full: stall. P holds and nothing is pushed.
    - Returns to IDLE when the next P is zero.
- At most one bit is served per cycle.
- FIFO: push and pop in the same cycle are both allowed. When full, push eligibility uses the registered full flag, so a simultaneous pop does not enable the push.
- Pop occurs when out_valid && out_ready. out_packet stays stable while out_valid=1 and out_ready=0.
- drop_count saturates at 16'hFFFF. overflow is set on the first drop.
- The routing-table read during SCAN uses the registered value. A cfg write to the index being served in the same cycle affects only later spikes.
- Reset mid-operation clears P, the FIFO, the FSM, the table, drop_count and overflow. No partial packet is emitted.

## Timing
- Reset values: out_packet=0, out_valid=0, busy=0, drop_count=0, overflow=0. FSM=IDLE.
- Latency: spike_valid at cycle t updates P at t+1, pushes at the end of t+1 if the table and FIFO allow, and raises out_valid at t+2.
- Throughput: one packet per cycle in and out. An N-spike timestep with no back-pressure drains in N cycles.
- busy falls the cycle after the last pop with P == 0.

## Test plan
- Table index 1 set to {1, 8'h10, 12'h005}, router_addr=8'h01, spike_in=4'b0010 with a strobe, out_ready=1 -> a single packet 32'h10005011 with out_valid high for exactly one cycle, at t+2.
- All four entries enabled, spike_in=4'b1111, out_ready=0 with FIFO_DEPTH=4 -> four packets queued with source indices 0,1,2,3 in order. out_packet stays stable. Raising out_ready drains one packet per cycle.
- Entry 2 disabled and the others enabled, spike_in=4'b0111 -> packets only for sources 0 and 1. drop_count stays 0.
- out_ready=0, FIFO full, bit 3 still pending, then spike_in=4'b1000 strobed again -> drop_count=1, overflow=1. P bit 3 stays set and is served once space frees.
- 70000 forced drops -> drop_count holds at 16'hFFFF.
- Assert rst while the FIFO holds 2 packets and P=4'b0101 -> next cycle out_valid=0, busy=0, and all table entries disabled, so a later strobe produces no packets.

Source files
------------

// File: rtl/spike_packetizer.sv
// Turns per-timestep spike masks into 32-bit NoC packets using a per-neuron routing table,
// serving one pending neuron per cycle into a small output FIFO toward the router local port.
module spike_packetizer #(
  parameter int NUM_NEURONS       = 4,
  parameter int ROUTER_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROUTER_ADDR_WIDTH-1:0] router_addr,
  input  logic [NUM_NEURONS-1:0]       spike_in,
  input  logic                         spike_valid,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_idx,
  input  logic [20:0]                  cfg_wdata,
  output logic [31:0]                  out_packet,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [15:0]                  drop_count,
  output logic                         overflow
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [20:0]            table_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] pend_q, pend_d;
  logic [0:0]             state_q, state_d;
  logic [15:0]            drop_q, drop_d;
  logic                   overflow_q, overflow_d;

  logic [31:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q;

  logic                   sel_found;
  logic [3:0]             sel_idx;
  logic [20:0]            sel_entry;
  logic [NUM_NEURONS-1:0] sel_onehot, served, drops;
  logic [4:0]             drop_inc;
  logic [16:0]            drop_sum;
  logic                   push, pop;
  logic [31:0]            push_pkt;

  // Loop-compare instead of indexing so writes with cfg_idx >= NUM_NEURONS fall through.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) table_q[i] <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (cfg_idx == 4'(i)) table_q[i] <= cfg_wdata;
      end
    end
  end

  // Lowest set bit wins: scanning downward lets the last hit be the lowest index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_entry  = '0;
    sel_onehot = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_found  = 1'b1;
        sel_idx    = 4'(i);
        sel_entry  = table_q[i];
        sel_onehot = NUM_NEURONS'(1) << i;
      end
    end
  end

  always_comb begin
    push     = (state_q == ST_SCAN) && sel_found && sel_entry[20] && !full_q;
    served   = '0;
    if ((state_q == ST_SCAN) && sel_found && (!sel_entry[20] || !full_q)) served = sel_onehot;
    push_pkt = {sel_entry[19:12], sel_entry[11:0], 8'(router_addr), sel_idx};

    pend_d = pend_q & ~served;
    drops  = '0;
    if (spike_valid) begin
      drops  = pend_d & spike_in;
      pend_d = pend_d | spike_in;
    end
    state_d = (|pend_d) ? ST_SCAN : ST_IDLE;

    drop_inc = '0;
    for (int i = 0; i < NUM_NEURONS; i++) drop_inc = drop_inc + {4'b0, drops[i]};
    drop_sum   = {1'b0, drop_q} + {12'b0, drop_inc};
    drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (|drops);

    pop     = (count_q != '0) && out_ready;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      pend_q     <= '0;
      state_q    <= ST_IDLE;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      state_q    <= state_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(FIFO_DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: FIFO storage is not reset; out_packet is gated by out_valid so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_pkt;
  end

  assign out_valid  = (count_q != '0);
  assign out_packet = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy       = (|pend_q) || out_valid;
  assign drop_count = drop_q;
  assign overflow   = overflow_q;

endmodule
